// File: rtl/caddr_boot_seq.sv
// Power-on reset and boot-key sequencer in front of the caddr CPU: holds the CPU
// in reset, pulses boot1_n/boot2_n, and replays the sequence on a debounced two-key press.
module caddr_boot_seq #(
  parameter int unsigned RESET_CYCLES    = 13,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned BOOT_CYCLES     = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       power_reset_n,
  input  logic       boot1_key_n,
  input  logic       boot2_key_n,
  output logic       cpu_reset_n,
  output logic       boot1_n,
  output logic       boot2_n,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_GAP   = 2'd1,
    ST_PULSE = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [15:0] RESET_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] BOOT_LAST  = 16'(BOOT_CYCLES - 1);
  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Reset synchronizer: asserts asynchronously, releases on the 2nd clk edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge power_reset_n) begin
    if (!power_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Key synchronizers run from the raw reset so a key already held during
  // power-up is seen as pressed on the first edge the sequencer is live.
  // ---------------------------------------------------------------------------
  logic [1:0] key1_sync_q;
  logic [1:0] key2_sync_q;
  logic [1:0] key_smp;

  always_ff @(posedge clk or negedge power_reset_n) begin
    if (!power_reset_n) begin
      key1_sync_q <= 2'b11;
      key2_sync_q <= 2'b11;
    end else begin
      key1_sync_q <= {key1_sync_q[0], boot1_key_n};
      key2_sync_q <= {key2_sync_q[0], boot2_key_n};
    end
  end

  assign key_smp = {key2_sync_q[1], key1_sync_q[1]};

  // ---------------------------------------------------------------------------
  // Debouncers: level flips after DEBOUNCE_CYCLES consecutive differing samples.
  // ---------------------------------------------------------------------------
  logic [1:0]  deb_lvl_q;
  logic [1:0]  deb_lvl_d;
  logic [15:0] deb_cnt_q [2];
  logic [15:0] deb_cnt_d [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_lvl_d[k] = deb_lvl_q[k];
      deb_cnt_d[k] = 16'd0;
      if (key_smp[k] != deb_lvl_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          deb_lvl_d[k] = ~deb_lvl_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      deb_lvl_q    <= 2'b11;
      deb_cnt_q[0] <= 16'd0;
      deb_cnt_q[1] <= 16'd0;
    end else begin
      deb_lvl_q    <= deb_lvl_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM.
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        cpu_reset_n_q, cpu_reset_n_d;
  logic        boot_n_q, boot_n_d;
  logic        busy_q, busy_d;
  logic        keys_released;
  logic        keys_pressed;
  logic        restart;

  // Released means debounced high and the live sample agrees, so the reset
  // default of the debouncers never arms a restart while keys are held.
  assign keys_released = (&deb_lvl_q) & (&key_smp);
  assign keys_pressed  = ~|deb_lvl_q;
  assign restart       = (state_q == ST_RUN) && armed_q && keys_pressed;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    armed_d = armed_q;

    if (restart) begin
      armed_d = 1'b0;
    end else if (keys_released) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == RESET_LAST) begin
          state_d = ST_GAP;
          cnt_d   = 16'd0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_PULSE;
          cnt_d   = 16'd0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
        end
      end
      ST_RUN: begin
        cnt_d = 16'd0;
        if (restart) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 16'd0;
      end
    endcase

    // Outputs are registered from the next state so pins change on the transition edge.
    cpu_reset_n_d = (state_d != ST_HOLD);
    boot_n_d      = (state_d != ST_PULSE);
    busy_d        = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= ST_HOLD;
      cnt_q         <= 16'd0;
      armed_q       <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      boot_n_q      <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      boot_n_q      <= boot_n_d;
      busy_q        <= busy_d;
    end
  end

  assign cpu_reset_n = cpu_reset_n_q;
  assign boot1_n     = boot_n_q;
  assign boot2_n     = boot_n_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
